lv_owt_tx_arb: RTL and testbench

- Shares the LV-to-HV one-wire (OWT) transmit channel between three requesters:
  - the LV control FSM watchdog/com-error frame (highest priority),
  - SPI-forwarded register accesses,
  - an internal periodic HV status poll (lowest priority).
- Serialises one transaction at a time: grant, send, wait for response, then retry on timeout or CRC error.
- Returns ack/err and response data to the owner of each transaction.
- Sits between lv_ctrl_unit/SPI slave and the OWT PHY (tx/rx framer).

---
 rtl/lv_owt_tx_arb_pkg.sv | 23 ++
 rtl/lv_owt_tx_arb_poll_tmr.sv | 56 +++++
 rtl/lv_owt_tx_arb.sv | 232 +++++++++++++++++++++++
 tb/tb_lv_owt_tx_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lv_owt_tx_arb_pkg.sv
// Shared constants and types for the LV-to-HV one-wire transmit arbiter.
package lv_owt_tx_arb_pkg;

    localparam int unsigned OWT_CMD_W    = 8;
    localparam int unsigned OWT_DATA_W   = 16;
    localparam int unsigned OWT_ARB_ST_W = 2;

    localparam logic [OWT_CMD_W-1:0] OWT_WDG_CMD  = 8'hA5;
    localparam logic [OWT_CMD_W-1:0] OWT_POLL_CMD = 8'h5A;

    typedef enum logic [OWT_ARB_ST_W-1:0] {
        OWT_IDLE_ST = 2'd0,
        OWT_SEND_ST = 2'd1,
        OWT_WAIT_ST = 2'd2
    } owt_arb_st_e;

    typedef enum logic [1:0] {
        OWT_OWN_WDG  = 2'd0,
        OWT_OWN_SPI  = 2'd1,
        OWT_OWN_POLL = 2'd2
    } owt_own_e;

endpackage

// File: rtl/lv_owt_tx_arb_poll_tmr.sv
// Periodic HV status-poll timer: raises poll_pend once per period and holds it
// until the arbiter grants the poll frame.
module lv_owt_poll_tmr #(
    parameter int unsigned POLL_PRD_CYC = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_owt_com_en,
    input  logic i_poll_en,
    input  logic i_grant_clr,
    output logic o_poll_pend
);

    localparam int unsigned CNT_W = (POLL_PRD_CYC > 1) ? $clog2(POLL_PRD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(POLL_PRD_CYC - 1);

    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             poll_pend_q, poll_pend_d;

    // Next-state for the period counter and the pending flag.
    always_comb begin
        poll_cnt_d  = poll_cnt_q;
        poll_pend_d = poll_pend_q;
        if (!i_owt_com_en) begin
            poll_cnt_d  = '0;
            poll_pend_d = 1'b0;
        end else begin
            if (i_grant_clr) begin
                poll_pend_d = 1'b0;
            end
            if (!i_poll_en) begin
                poll_cnt_d = '0;
            end else if (poll_cnt_q == CNT_TERM) begin
                // A tick coinciding with a grant starts a new period, so set wins.
                poll_cnt_d  = '0;
                poll_pend_d = 1'b1;
            end else begin
                poll_cnt_d = poll_cnt_q + 1'b1;
            end
        end
    end

    // Timer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            poll_cnt_q  <= '0;
            poll_pend_q <= 1'b0;
        end else begin
            poll_cnt_q  <= poll_cnt_d;
            poll_pend_q <= poll_pend_d;
        end
    end

    assign o_poll_pend = poll_pend_q;

endmodule

// File: rtl/lv_owt_tx_arb.sv
// Arbitrates the LV-to-HV one-wire transmit channel between the watchdog
// frame, SPI-forwarded accesses and the periodic status poll; one transaction
// at a time with timeout/CRC retry and ack/err reporting to the owner.
module lv_owt_tx_arb
    import lv_owt_tx_arb_pkg::*;
#(
    parameter int unsigned ACK_TMO_CYC  = 1024,
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned POLL_PRD_CYC = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_owt_com_en,
    input  logic                    i_poll_en,
    input  logic                    i_fsm_wdg_req,
    output logic                    o_fsm_wdg_ack,
    output logic                    o_fsm_wdg_err,
    input  logic                    i_spi_req,
    input  logic [OWT_CMD_W-1:0]    i_spi_cmd,
    input  logic [OWT_DATA_W-1:0]   i_spi_wdata,
    output logic                    o_spi_ack,
    output logic                    o_spi_err,
    output logic [OWT_DATA_W-1:0]   o_spi_rdata,
    output logic                    o_poll_upd,
    output logic [OWT_DATA_W-1:0]   o_poll_rdata,
    output logic                    o_owt_tx_vld,
    output logic [OWT_CMD_W-1:0]    o_owt_tx_cmd,
    output logic [OWT_DATA_W-1:0]   o_owt_tx_data,
    input  logic                    i_owt_tx_rdy,
    input  logic                    i_owt_rx_vld,
    input  logic [OWT_DATA_W-1:0]   i_owt_rx_data,
    input  logic                    i_owt_rx_crc_err,
    output logic                    o_owt_com_err,
    output logic [OWT_ARB_ST_W-1:0] o_arb_cur_st
);

    localparam int unsigned TMO_W = (ACK_TMO_CYC > 1) ? $clog2(ACK_TMO_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(ACK_TMO_CYC - 1);
    localparam int unsigned RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(RETRY_MAX);

    owt_arb_st_e             state_q, state_d;
    owt_own_e                owner_q, owner_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [RTY_W-1:0]        retry_cnt_q, retry_cnt_d;
    logic                    tx_vld_q, tx_vld_d;
    logic [OWT_CMD_W-1:0]    tx_cmd_q, tx_cmd_d;
    logic [OWT_DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                    wdg_ack_q, wdg_ack_d;
    logic                    wdg_err_q, wdg_err_d;
    logic                    spi_ack_q, spi_ack_d;
    logic                    spi_err_q, spi_err_d;
    logic [OWT_DATA_W-1:0]   spi_rdata_q, spi_rdata_d;
    logic                    poll_upd_q, poll_upd_d;
    logic [OWT_DATA_W-1:0]   poll_rdata_q, poll_rdata_d;
    logic                    com_err_q, com_err_d;

    logic poll_pend;
    logic poll_grant;
    logic wdg_elig;
    logic spi_elig;
    logic rsp_ok;
    logic rsp_fail;
    logic grant;

    lv_owt_poll_tmr #(
        .POLL_PRD_CYC (POLL_PRD_CYC)
    ) u_poll_tmr (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_owt_com_en (i_owt_com_en),
        .i_poll_en    (i_poll_en),
        .i_grant_clr  (poll_grant),
        .o_poll_pend  (poll_pend)
    );

    // A requester whose pulse is high this cycle is still holding req; mask it.
    assign wdg_elig = i_fsm_wdg_req & ~wdg_ack_q & ~wdg_err_q;
    assign spi_elig = i_spi_req & ~spi_ack_q & ~spi_err_q;
    assign rsp_ok   = i_owt_rx_vld & ~i_owt_rx_crc_err;
    assign rsp_fail = (i_owt_rx_vld & i_owt_rx_crc_err) | (tmo_cnt_q == TMO_TERM);

    // Arbitration, send/wait sequencing, retry and owner reporting.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        tmo_cnt_d    = tmo_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        tx_vld_d     = tx_vld_q;
        tx_cmd_d     = tx_cmd_q;
        tx_data_d    = tx_data_q;
        spi_rdata_d  = spi_rdata_q;
        poll_rdata_d = poll_rdata_q;
        wdg_ack_d    = 1'b0;
        wdg_err_d    = 1'b0;
        spi_ack_d    = 1'b0;
        spi_err_d    = 1'b0;
        poll_upd_d   = 1'b0;
        com_err_d    = 1'b0;
        poll_grant   = 1'b0;
        grant        = 1'b0;

        if (!i_owt_com_en) begin
            state_d     = OWT_IDLE_ST;
            tx_vld_d    = 1'b0;
            tmo_cnt_d   = '0;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                OWT_IDLE_ST: begin
                    if (wdg_elig) begin
                        grant     = 1'b1;
                        owner_d   = OWT_OWN_WDG;
                        tx_cmd_d  = OWT_WDG_CMD;
                        tx_data_d = '0;
                    end else if (spi_elig) begin
                        grant     = 1'b1;
                        owner_d   = OWT_OWN_SPI;
                        tx_cmd_d  = i_spi_cmd;
                        tx_data_d = i_spi_wdata;
                    end else if (poll_pend) begin
                        grant      = 1'b1;
                        poll_grant = 1'b1;
                        owner_d    = OWT_OWN_POLL;
                        tx_cmd_d   = OWT_POLL_CMD;
                        tx_data_d  = '0;
                    end
                    if (grant) begin
                        retry_cnt_d = '0;
                        tx_vld_d    = 1'b1;
                        state_d     = OWT_SEND_ST;
                    end
                end
                OWT_SEND_ST: begin
                    if (tx_vld_q && i_owt_tx_rdy) begin
                        tmo_cnt_d = '0;
                        tx_vld_d  = 1'b0;
                        state_d   = OWT_WAIT_ST;
                    end
                end
                OWT_WAIT_ST: begin
                    // A response in the timeout cycle takes precedence over the timeout.
                    if (rsp_ok) begin
                        state_d = OWT_IDLE_ST;
                        case (owner_q)
                            OWT_OWN_WDG: wdg_ack_d = 1'b1;
                            OWT_OWN_SPI: begin
                                spi_ack_d   = 1'b1;
                                spi_rdata_d = i_owt_rx_data;
                            end
                            default: begin
                                poll_upd_d   = 1'b1;
                                poll_rdata_d = i_owt_rx_data;
                            end
                        endcase
                    end else if (rsp_fail) begin
                        if (retry_cnt_q < RTY_LIM) begin
                            retry_cnt_d = retry_cnt_q + 1'b1;
                            tx_vld_d    = 1'b1;
                            state_d     = OWT_SEND_ST;
                        end else begin
                            state_d   = OWT_IDLE_ST;
                            com_err_d = 1'b1;
                            case (owner_q)
                                OWT_OWN_WDG: wdg_err_d = 1'b1;
                                OWT_OWN_SPI: spi_err_d = 1'b1;
                                default:     ;
                            endcase
                        end
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = OWT_IDLE_ST;
                    tx_vld_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= OWT_IDLE_ST;
            owner_q      <= OWT_OWN_WDG;
            tmo_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            tx_vld_q     <= 1'b0;
            tx_cmd_q     <= '0;
            tx_data_q    <= '0;
            wdg_ack_q    <= 1'b0;
            wdg_err_q    <= 1'b0;
            spi_ack_q    <= 1'b0;
            spi_err_q    <= 1'b0;
            spi_rdata_q  <= '0;
            poll_upd_q   <= 1'b0;
            poll_rdata_q <= '0;
            com_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            tx_vld_q     <= tx_vld_d;
            tx_cmd_q     <= tx_cmd_d;
            tx_data_q    <= tx_data_d;
            wdg_ack_q    <= wdg_ack_d;
            wdg_err_q    <= wdg_err_d;
            spi_ack_q    <= spi_ack_d;
            spi_err_q    <= spi_err_d;
            spi_rdata_q  <= spi_rdata_d;
            poll_upd_q   <= poll_upd_d;
            poll_rdata_q <= poll_rdata_d;
            com_err_q    <= com_err_d;
        end
    end

    assign o_fsm_wdg_ack = wdg_ack_q;
    assign o_fsm_wdg_err = wdg_err_q;
    assign o_spi_ack     = spi_ack_q;
    assign o_spi_err     = spi_err_q;
    assign o_spi_rdata   = spi_rdata_q;
    assign o_poll_upd    = poll_upd_q;
    assign o_poll_rdata  = poll_rdata_q;
    assign o_owt_tx_vld  = tx_vld_q;
    assign o_owt_tx_cmd  = tx_cmd_q;
    assign o_owt_tx_data = tx_data_q;
    assign o_owt_com_err = com_err_q;
    assign o_arb_cur_st  = state_q;

endmodule

// File: tb/tb_lv_owt_tx_arb.sv
// Self-checking bench for lv_owt_tx_arb: a frame/pulse scoreboard filled by
// the directed tests, a PHY responder, and literal timing expectations.
module tb_lv_owt_tx_arb;

    localparam int unsigned ACK_TMO_CYC  = 1024;
    localparam int unsigned RETRY_MAX    = 3;
    localparam int unsigned POLL_PRD_CYC = 4096;

    // Pulse vector order: {wdg_ack, wdg_err, spi_ack, spi_err, poll_upd, com_err}
    localparam logic [5:0] EV_WDG_ACK  = 6'b100000;
    localparam logic [5:0] EV_SPI_ACK  = 6'b001000;
    localparam logic [5:0] EV_SPI_ERR  = 6'b000101;
    localparam logic [5:0] EV_POLL_UPD = 6'b000010;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
    } frm_t;

    typedef struct {
        logic [5:0]  vec;
        logic [15:0] data;
    } evt_t;

    typedef struct {
        int          dly;
        logic        none;
        logic [15:0] data;
        logic        crc;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        com_en;
    logic        poll_en;
    logic        wdg_req;
    logic        spi_req;
    logic [7:0]  spi_cmd;
    logic [15:0] spi_wdata;
    logic        tx_rdy;
    logic        rx_vld;
    logic [15:0] rx_data;
    logic        rx_crc;

    logic        o_fsm_wdg_ack;
    logic        o_fsm_wdg_err;
    logic        o_spi_ack;
    logic        o_spi_err;
    logic [15:0] o_spi_rdata;
    logic        o_poll_upd;
    logic [15:0] o_poll_rdata;
    logic        o_owt_tx_vld;
    logic [7:0]  o_owt_tx_cmd;
    logic [15:0] o_owt_tx_data;
    logic        o_owt_com_err;
    logic [1:0]  o_arb_cur_st;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frm_t exp_frm[$];
    evt_t exp_evt[$];
    rsp_t rsp_q[$];
    int   hs_cyc[$];

    lv_owt_tx_arb #(
        .ACK_TMO_CYC  (ACK_TMO_CYC),
        .RETRY_MAX    (RETRY_MAX),
        .POLL_PRD_CYC (POLL_PRD_CYC)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_owt_com_en     (com_en),
        .i_poll_en        (poll_en),
        .i_fsm_wdg_req    (wdg_req),
        .o_fsm_wdg_ack    (o_fsm_wdg_ack),
        .o_fsm_wdg_err    (o_fsm_wdg_err),
        .i_spi_req        (spi_req),
        .i_spi_cmd        (spi_cmd),
        .i_spi_wdata      (spi_wdata),
        .o_spi_ack        (o_spi_ack),
        .o_spi_err        (o_spi_err),
        .o_spi_rdata      (o_spi_rdata),
        .o_poll_upd       (o_poll_upd),
        .o_poll_rdata     (o_poll_rdata),
        .o_owt_tx_vld     (o_owt_tx_vld),
        .o_owt_tx_cmd     (o_owt_tx_cmd),
        .o_owt_tx_data    (o_owt_tx_data),
        .i_owt_tx_rdy     (tx_rdy),
        .i_owt_rx_vld     (rx_vld),
        .i_owt_rx_data    (rx_data),
        .i_owt_rx_crc_err (rx_crc),
        .o_owt_com_err    (o_owt_com_err),
        .o_arb_cur_st     (o_arb_cur_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return o_fsm_wdg_ack;
            1:       return o_fsm_wdg_err;
            2:       return o_spi_ack;
            3:       return o_spi_err;
            4:       return o_poll_upd;
            5:       return o_owt_com_err;
            default: return o_owt_tx_vld;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge where the selected output is seen high.
    task automatic wait_hi(input int sel, input int budget, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic push_frm(input logic [7:0] c, input logic [15:0] d, input int n);
        frm_t f;
        f.cmd  = c;
        f.data = d;
        for (int i = 0; i < n; i++) exp_frm.push_back(f);
    endtask

    task automatic push_rsp(input int dly, input logic none, input logic [15:0] d, input logic crc);
        rsp_t r;
        r.dly  = dly;
        r.none = none;
        r.data = d;
        r.crc  = crc;
        rsp_q.push_back(r);
    endtask

    task automatic push_evt(input logic [5:0] v, input logic [15:0] d);
        evt_t e;
        e.vec  = v;
        e.data = d;
        exp_evt.push_back(e);
    endtask

    // PHY model: each accepted frame consumes one planned response.
    initial begin : responder
        int   pend;
        rsp_t cur;
        rsp_t r;
        pend    = 0;
        rx_vld  = 1'b0;
        rx_data = '0;
        rx_crc  = 1'b0;
        cur     = '{0, 1'b1, 16'h0, 1'b0};
        forever begin
            @(negedge clk);
            rx_vld = 1'b0;
            rx_crc = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rx_vld  = 1'b1;
                    rx_data = cur.data;
                    rx_crc  = cur.crc;
                end
            end
            if (rst_n && o_owt_tx_vld && tx_rdy && rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                if (!r.none) begin
                    cur  = r;
                    pend = r.dly;
                end
            end
        end
    end

    // Scoreboard: every handshake and every pulse must match the next expectation.
    initial begin : compare
        logic       prev_stall;
        logic [7:0] prev_cmd;
        logic [15:0] prev_data;
        logic [5:0] pv;
        frm_t       f;
        evt_t       e;
        prev_stall = 1'b0;
        prev_cmd   = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall && o_owt_tx_vld) begin
                    chk("tx_cmd_stable", 32'(o_owt_tx_cmd), 32'(prev_cmd));
                    chk("tx_data_stable", 32'(o_owt_tx_data), 32'(prev_data));
                end
                if (o_owt_tx_vld && tx_rdy) begin
                    hs_cyc.push_back(cyc);
                    chk("frame_expected", 32'(exp_frm.size() != 0), 32'd1);
                    if (exp_frm.size() != 0) begin
                        f = exp_frm.pop_front();
                        chk("frame_cmd", 32'(o_owt_tx_cmd), 32'(f.cmd));
                        chk("frame_data", 32'(o_owt_tx_data), 32'(f.data));
                    end
                end
                pv = {o_fsm_wdg_ack, o_fsm_wdg_err, o_spi_ack, o_spi_err, o_poll_upd, o_owt_com_err};
                if (pv != 6'b0) begin
                    chk("pulse_expected", 32'(exp_evt.size() != 0), 32'd1);
                    if (exp_evt.size() != 0) begin
                        e = exp_evt.pop_front();
                        chk("pulse_vec", 32'(pv), 32'(e.vec));
                        if (e.vec[3]) chk("spi_rdata", 32'(o_spi_rdata), 32'(e.data));
                        if (e.vec[1]) chk("poll_rdata", 32'(o_poll_rdata), 32'(e.data));
                    end
                end
                prev_stall = o_owt_tx_vld & ~tx_rdy;
                prev_cmd   = o_owt_tx_cmd;
                prev_data  = o_owt_tx_data;
            end
        end
    end

    initial begin : guard
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin : main
        int tgt;
        rst_n     = 1'b0;
        com_en    = 1'b0;
        poll_en   = 1'b0;
        wdg_req   = 1'b0;
        spi_req   = 1'b0;
        spi_cmd   = '0;
        spi_wdata = '0;
        tx_rdy    = 1'b1;
        tick(3);

        chk("rst_tx_vld", 32'(o_owt_tx_vld), 32'd0);
        chk("rst_tx_cmd", 32'(o_owt_tx_cmd), 32'd0);
        chk("rst_tx_data", 32'(o_owt_tx_data), 32'd0);
        chk("rst_state", 32'(o_arb_cur_st), 32'd0);
        chk("rst_spi_rdata", 32'(o_spi_rdata), 32'd0);
        chk("rst_poll_rdata", 32'(o_poll_rdata), 32'd0);
        chk("rst_pulses", 32'({o_fsm_wdg_ack, o_fsm_wdg_err, o_spi_ack, o_spi_err, o_poll_upd, o_owt_com_err}), 32'd0);

        rst_n  = 1'b1;
        com_en = 1'b1;
        tick(3);

        // Watchdog and SPI together: watchdog first, then SPI.
        hs_cyc.delete();
        push_frm(8'hA5, 16'h0000, 1);
        push_frm(8'h3C, 16'h00AA, 1);
        push_rsp(10, 1'b0, 16'h1234, 1'b0);
        push_rsp(10, 1'b0, 16'h1234, 1'b0);
        push_evt(EV_WDG_ACK, 16'h0);
        push_evt(EV_SPI_ACK, 16'h1234);
        wdg_req   = 1'b1;
        spi_req   = 1'b1;
        spi_cmd   = 8'h3C;
        spi_wdata = 16'h00AA;
        tick(1);
        chk("t1_vld_latency", 32'(o_owt_tx_vld), 32'd1);
        chk("t1_first_cmd", 32'(o_owt_tx_cmd), 32'hA5);
        chk("t1_state_send", 32'(o_arb_cur_st), 32'd1);
        wait_hi(0, 100, "t1_wdg_ack_seen");
        wdg_req = 1'b0;
        wait_hi(2, 100, "t1_spi_ack_seen");
        spi_req = 1'b0;
        chk("t1_spi_rdata", 32'(o_spi_rdata), 32'h1234);
        chk("t1_hs_count", 32'(hs_cyc.size()), 32'd2);
        tick(5);

        // No response: 1 + RETRY_MAX sends, then SPI error and com error.
        hs_cyc.delete();
        push_frm(8'h11, 16'h2222, RETRY_MAX + 1);
        for (int i = 0; i < RETRY_MAX + 1; i++) push_rsp(0, 1'b1, 16'h0, 1'b0);
        push_evt(EV_SPI_ERR, 16'h0);
        spi_cmd   = 8'h11;
        spi_wdata = 16'h2222;
        spi_req   = 1'b1;
        wait_hi(3, 6000, "t2_spi_err_seen");
        spi_req = 1'b0;
        chk("t2_state_idle", 32'(o_arb_cur_st), 32'd0);
        chk("t2_hs_count", 32'(hs_cyc.size()), 32'd4);
        // Resend gap: ACK_TMO_CYC cycles waiting plus the SEND cycle of the retry.
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t2_retry_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(ACK_TMO_CYC + 1));
        tick(20);
        chk("t2_no_more_frames", 32'(hs_cyc.size()), 32'd4);

        // CRC error then good response.
        hs_cyc.delete();
        push_frm(8'h22, 16'h0033, 2);
        push_rsp(5, 1'b0, 16'hDEAD, 1'b1);
        push_rsp(5, 1'b0, 16'hBEEF, 1'b0);
        push_evt(EV_SPI_ACK, 16'hBEEF);
        spi_cmd   = 8'h22;
        spi_wdata = 16'h0033;
        spi_req   = 1'b1;
        wait_hi(2, 200, "t3_spi_ack_seen");
        spi_req = 1'b0;
        chk("t3_spi_rdata", 32'(o_spi_rdata), 32'hBEEF);
        chk("t3_hs_count", 32'(hs_cyc.size()), 32'd2);
        tick(5);

        // Response in the same cycle as the timeout terminal count.
        hs_cyc.delete();
        push_frm(8'h44, 16'h5555, 1);
        push_rsp(ACK_TMO_CYC, 1'b0, 16'hC0DE, 1'b0);
        push_evt(EV_SPI_ACK, 16'hC0DE);
        spi_cmd   = 8'h44;
        spi_wdata = 16'h5555;
        spi_req   = 1'b1;
        wait_hi(2, 3000, "t6_spi_ack_seen");
        spi_req = 1'b0;
        chk("t6_spi_rdata", 32'(o_spi_rdata), 32'hC0DE);
        tick(5);
        chk("t6_hs_count", 32'(hs_cyc.size()), 32'd1);

        // Abort in SEND (after one timeout) and resend from retry 0 after re-enable.
        hs_cyc.delete();
        push_frm(8'h66, 16'h7777, 1);
        push_rsp(0, 1'b1, 16'h0, 1'b0);
        spi_cmd   = 8'h66;
        spi_wdata = 16'h7777;
        spi_req   = 1'b1;
        wait_hi(6, 50, "t5_first_vld");
        tick(1);
        tx_rdy = 1'b0;
        wait_hi(6, 1100, "t5_retry_vld");
        tick(2);
        chk("t5_stalled_in_send", 32'(o_arb_cur_st), 32'd1);
        com_en = 1'b0;
        tick(1);
        chk("t5_abort_vld", 32'(o_owt_tx_vld), 32'd0);
        chk("t5_abort_state", 32'(o_arb_cur_st), 32'd0);
        tick(5);
        chk("t5_abort_hold_state", 32'(o_arb_cur_st), 32'd0);
        push_frm(8'h66, 16'h7777, RETRY_MAX + 1);
        for (int i = 0; i < RETRY_MAX; i++) push_rsp(0, 1'b1, 16'h0, 1'b0);
        push_rsp(3, 1'b0, 16'h1357, 1'b0);
        push_evt(EV_SPI_ACK, 16'h1357);
        tx_rdy = 1'b1;
        com_en = 1'b1;
        wait_hi(2, 6000, "t5_spi_ack_seen");
        spi_req = 1'b0;
        chk("t5_hs_count", 32'(hs_cyc.size()), 32'(RETRY_MAX + 2));
        tick(5);

        // Periodic poll, then SPI held across a poll tick.
        hs_cyc.delete();
        push_frm(8'h5A, 16'h0000, 2);
        push_rsp(3, 1'b0, 16'hA001, 1'b0);
        push_rsp(3, 1'b0, 16'hA002, 1'b0);
        push_evt(EV_POLL_UPD, 16'hA001);
        push_evt(EV_POLL_UPD, 16'hA002);
        poll_en = 1'b1;
        wait_hi(4, POLL_PRD_CYC + 100, "t4_poll1_seen");
        wait_hi(4, POLL_PRD_CYC + 100, "t4_poll2_seen");
        chk("t4_poll_rdata", 32'(o_poll_rdata), 32'hA002);
        chk("t4_poll_count", 32'(hs_cyc.size()), 32'd2);
        if (hs_cyc.size() == 2) begin
            chk("t4_poll_period", 32'(hs_cyc[1] - hs_cyc[0]), 32'(POLL_PRD_CYC));
            tgt = hs_cyc[1] + POLL_PRD_CYC - 4;
        end else begin
            tgt = cyc + 10;
        end
        push_frm(8'h77, 16'h0088, 1);
        push_frm(8'h5A, 16'h0000, 1);
        push_rsp(20, 1'b0, 16'h4242, 1'b0);
        push_rsp(3, 1'b0, 16'hA003, 1'b0);
        push_evt(EV_SPI_ACK, 16'h4242);
        push_evt(EV_POLL_UPD, 16'hA003);
        while (cyc < tgt) @(negedge clk);
        spi_cmd   = 8'h77;
        spi_wdata = 16'h0088;
        spi_req   = 1'b1;
        wait_hi(2, 200, "t4_spi_ack_seen");
        spi_req = 1'b0;
        wait_hi(4, 200, "t4_poll3_seen");
        poll_en = 1'b0;
        chk("t4_poll3_rdata", 32'(o_poll_rdata), 32'hA003);
        tick(10);

        chk("end_frames_consumed", 32'(exp_frm.size()), 32'd0);
        chk("end_pulses_consumed", 32'(exp_evt.size()), 32'd0);
        chk("end_rsp_consumed", 32'(rsp_q.size()), 32'd0);
        chk("end_state_idle", 32'(o_arb_cur_st), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
